// File: rtl/serial_subtractor.sv
// Bit-serial a - b as a + ~b + 1 with one full-adder cell and a registered carry.
// One bit per clock; result, borrow and overflow are registered on the final bit.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             sum_bit, carry_bit, last_bit;

  assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign carry_bit = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = carry_bit;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB; carry_bit is the carry out of it
          diff_d   = {sum_bit, res_q[WIDTH-1:1]};
          borrow_d = ~carry_bit;
          ovf_d    = carry_q ^ carry_bit;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 8-bit and 4-bit instances, expected results queued
// at issue time and popped by per-instance monitors on each done pulse.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy8, done8, borrow8, ovf8;
  logic       busy4, done4, borrow4, ovf4;
  logic [7:0] diff8;
  logic [3:0] diff4;

  int n_cmp = 0;
  int n_fail = 0;
  logic [9:0] q8[$];
  logic [9:0] q4[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8), .overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4), .overflow(ovf4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {borrow, overflow, diff} from plain integer arithmetic.
  function automatic logic [9:0] model(input int w, input int a, input int b);
    int mask, d, sa, sb, sd;
    logic br, ov;
    logic [7:0] d8;
    mask = (1 << w) - 1;
    d    = (a - b) & mask;
    br   = (a < b);
    sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sd   = sa - sb;
    ov   = (sd < -(1 << (w - 1))) || (sd > (1 << (w - 1)) - 1);
    d8   = 8'(d);
    return {br, ov, d8};
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 8) ? done8 : done4;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done8 === 1'b1) begin
      if (q8.size() == 0) chk("w8_unexpected_done", 1, 0);
      else chk("w8_result", {borrow8, ovf8, diff8}, q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4 === 1'b1) begin
      if (q4.size() == 0) chk("w4_unexpected_done", 1, 0);
      else chk("w4_result", {borrow4, ovf4, 4'h0, diff4}, q4.pop_front());
    end
  end

  // Issue one operation as soon as the instance is idle; returns at the done negedge.
  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_of(w) !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_start", busy_of(w), 0);
    if (w == 8) begin
      a8 = a; b8 = b; start8 = 1'b1;
      q8.push_back(model(8, a, b));
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1;
      q4.push_back(model(4, a & 8'h0f, b & 8'h0f));
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start8 = 1'b0;
        start4 = 1'b0;
      end
    end while (done_of(w) !== 1'b1 && n < 50);
    chk("done_latency", n, w + 1);
  endtask

  initial begin
    logic [7:0] ra, rb;

    // Reset held with start asserted: everything stays quiet.
    start8 = 1'b1; start4 = 1'b1; a8 = 8'h5a; b8 = 8'h33;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs8", {busy8, done8, borrow8, ovf8, diff8}, 0);
      chk("rst_outputs4", {busy4, done4, borrow4, ovf4, diff4}, 0);
    end
    start8 = 1'b0; start4 = 1'b0; rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_rst", {busy8, busy4}, 0);
    end

    // Basic subtraction, then outputs hold while idle.
    do_op(8, 8'd5, 8'd3);
    repeat (3) begin
      @(negedge clk);
      chk("hold_diff", {busy8, diff8}, {1'b0, 8'h02});
    end

    do_op(8, 8'd3, 8'd5);
    do_op(8, 8'h80, 8'h01);
    do_op(8, 8'h7f, 8'hff);
    do_op(8, 8'h3c, 8'h3c);
    do_op(8, 8'ha7, 8'h00);

    // Start held high, operands disturbed mid-shift, start present during DONE.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    q8.push_back(model(8, 8'h10, 8'h01));
    for (int op = 0; op < 3; op++) begin
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (c == 3) begin
          a8 = 8'($urandom_range(255));
          b8 = 8'($urandom_range(255));
        end
        if (c == 8) begin
          a8 = 8'h10; b8 = 8'h01;
          chk("held_no_early_done", done8, 0);
        end
        if (c == 9) chk("held_done_cycle", done8, 1);
        if (c == 10) begin
          chk("start_in_done_ignored", busy8, 0);
          if (op < 2) q8.push_back(model(8, 8'h10, 8'h01));
          else start8 = 1'b0;
        end
      end
    end

    // Reset in the middle of a shift aborts without a done pulse.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_outputs", {busy8, done8, borrow8, ovf8, diff8}, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", {busy8, done8}, 0);
    end
    do_op(8, 8'haa, 8'h55);

    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      do_op(8, ra, rb);
    end

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        do_op(4, 8'(x), 8'(y));

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
